mandel_pixel_scheduler: RTL and testbench
=========================================

# mandel_pixel_scheduler

Frame-level scheduler that shares pixel jobs between two mandelbrot engine instances and retires their iteration counts to the VGA framebuffer in strict raster order. It replaces the single-engine render state machine in the top level. It sits between the serial-config start strobe, the engines (`run`/`running`/`ctr_out`) and the framebuffer write port (`write_data`/`wrote_data`/`reset_write_ptr`).

## Interface
- WIDTH, 400, pixels per line
- HEIGHT, 300, lines per frame
- clk  in  1  clock
- combined_rst_n  in  1  reset combined_rst_n, asynchronous, active-low; clock clk
- start  in  1  one-cycle frame start strobe (synchronised sen falling edge)
- eng_run  out  2  one-cycle job launch per engine
- eng_x  out  $clog2(WIDTH)  column of launched job, valid while any eng_run bit is high
- eng_y  out  $clog2(HEIGHT)  row of launched job, valid while any eng_run bit is high
- eng_busy  in  2  engine `running` flags
- eng_ctr0, eng_ctr1  in  4  engine `ctr_out`, valid on the busy falling edge
- fb_reset_ptr  out  1  one-cycle framebuffer write-pointer reset
- fb_write  out  1  one-cycle write request
- fb_data  out  4  pixel value, held from fb_write until fb_wrote
- fb_wrote  in  1  framebuffer write acknowledge
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel is retired

## Operation
- States: IDLE, RUN.
- IDLE + start: pulse fb_reset_ptr; clear coordinates, retired count, dispatch pointer, retire pointer, result slots; enter RUN. start is ignored in RUN.
- Per engine: an inflight flag plus a result slot (4-bit value and valid bit).
- Dispatch, in RUN:
  - Conditions: pixels remain undispatched, and engine[disp_ptr] has inflight=0 and slot empty.
  - Action: pulse eng_run[disp_ptr] with the current x,y; set inflight; toggle disp_ptr.
  - Coordinate step: x increments and wraps from WIDTH-1 to 0, which increments y. Stop after pixel (WIDTH-1, HEIGHT-1).
- Completion:
  - Detection: registered l_busy[i]=1, eng_busy[i]=0 and inflight[i]=1.
  - Action: capture eng_ctr_i into slot i, set valid, clear inflight.
  - Both engines may complete in the same cycle; both are captured.
- Retire:
  - Conditions: slot[ret_ptr] valid and no write outstanding.
  - Action: drive fb_data from the slot, pulse fb_write, mark outstanding.
  - On fb_wrote: clear the slot and outstanding, toggle ret_ptr, increment the retired count.
  - Round-robin dispatch plus round-robin retire guarantees raster order even if engine 1 finishes first.
- Frame end: when retired count reaches WIDTH*HEIGHT, pulse frame_done and enter IDLE.
- Widths: retired count is $clog2(WIDTH*HEIGHT+1) bits.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; all flags, pointers and counters 0.
  - Asynchronous reset mid-frame aborts immediately; the next start restarts at (0,0).
- fb_reset_ptr is asserted in the cycle after start. The first eng_run is asserted in the cycle after fb_reset_ptr.
- eng_run is one cycle wide. The engine must raise busy within 1 cycle. Inflight masks the engine from redispatch in the meantime.
- A slot is captured 1 cycle after the busy falling edge is seen on the registered busy.
- fb_write is asserted at the earliest in the cycle after capture. At most one write is outstanding. fb_wrote may arrive any cycle ≥1 after fb_write.
- fb_wrote and a new completion in the same cycle are both honoured.
- frame_done is asserted in the cycle after the final fb_wrote. busy deasserts in that same cycle.

## Configuration
- Macro: MANDEL_DUAL_ENGINE_EN.
- Defined: two-engine scheduling as described above.
- Undefined:
  - disp_ptr and ret_ptr are tied to 0.
  - eng_run[1] is constant 0; eng_busy[1] and eng_ctr1 are ignored.
  - All pixels go through engine 0 sequentially.
  - Port list is unchanged.

## Structure
- Package mandel_sched_pkg holds:
  - state enum (IDLE, RUN)
  - default WIDTH/HEIGHT constants
  - CTR_OUT_W=4
- Sub-module mandel_result_slot contains inflight, l_busy, falling-edge capture and the valid bit. It is instantiated once per engine.

## Test plan
- Reset with all inputs 0 → every output 0, busy=0.
- WIDTH=4, HEIGHT=2; both engines model a 5-cycle latency, eng0 returns 3 and eng1 returns 7; fb_wrote 2 cycles after fb_write → eng_x/eng_y sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); fb_data 3,7,3,7,3,7,3,7; exactly one frame_done.
- eng0 latency 20, eng1 latency 2 → fb_data order still alternates eng0, eng1; eng1 is not relaunched until its slot is retired.
- fb_wrote delayed 10 cycles → never two fb_write without an intervening fb_wrote; fb_data stable while waiting; dispatch stalls once both slots are full.
- start pulsed during RUN → ignored, no extra fb_reset_ptr. Assert reset at pixel 5 → outputs 0 immediately. A new start → fb_reset_ptr, then restart at (0,0).
- MANDEL_DUAL_ENGINE_EN undefined → eng_run[1] never high; all 8 pixels on engine 0; fb_data is all 3.

Source files
------------

// File: rtl/mandel_sched_pkg.sv
// mandel_sched_pkg: shared state type and frame constants
// for the two-engine mandelbrot pixel scheduler.
package mandel_sched_pkg;
  localparam int DEF_WIDTH  = 400;
  localparam int DEF_HEIGHT = 300;
  localparam int CTR_OUT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;
endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// mandel_pixel_scheduler_if: engine launch/result lanes and
// framebuffer write port between scheduler and datapath.
interface mandel_pixel_scheduler_if
  import mandel_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) ();
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [1:0]           eng_run;
  logic [XW-1:0]        eng_x;
  logic [YW-1:0]        eng_y;
  logic [1:0]           eng_busy;
  logic [CTR_OUT_W-1:0] eng_ctr0;
  logic [CTR_OUT_W-1:0] eng_ctr1;
  logic                 fb_reset_ptr;
  logic                 fb_write;
  logic [CTR_OUT_W-1:0] fb_data;
  logic                 fb_wrote;

  modport master (
    output eng_run, eng_x, eng_y,
    output fb_reset_ptr, fb_write, fb_data,
    input  eng_busy, eng_ctr0, eng_ctr1,
    input  fb_wrote
  );

  modport slave (
    input  eng_run, eng_x, eng_y,
    input  fb_reset_ptr, fb_write, fb_data,
    output eng_busy, eng_ctr0, eng_ctr1,
    output fb_wrote
  );
endinterface

// File: rtl/mandel_result_slot.sv
// mandel_result_slot: per-engine inflight flag, busy falling
// edge detect and one-entry result buffer.
module mandel_result_slot
  import mandel_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 combined_rst_n,
  input  logic                 i_clr,
  input  logic                 i_launch,
  input  logic                 i_busy,
  input  logic [CTR_OUT_W-1:0] i_ctr,
  input  logic                 i_take,
  output logic                 o_inflight,
  output logic                 o_valid,
  output logic [CTR_OUT_W-1:0] o_value
);
  logic                 r_l_busy;
  logic                 r_inflight;
  logic                 r_valid;
  logic [CTR_OUT_W-1:0] r_value;
  logic                 w_done;

  assign w_done = r_l_busy & ~i_busy & r_inflight;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      r_l_busy   <= 1'b0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_value    <= '0;
    end else if (i_clr) begin
      r_l_busy   <= 1'b0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_value    <= '0;
    end else begin
      r_l_busy <= i_busy;
      if (i_launch)    r_inflight <= 1'b1;
      else if (w_done) r_inflight <= 1'b0;
      if (w_done) begin
        r_valid <= 1'b1;
        r_value <= i_ctr;
      end else if (i_take) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_inflight = r_inflight;
  assign o_valid    = r_valid;
  assign o_value    = r_value;
endmodule

// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: round-robin pixel dispatch to two engines,
// in-order retire to framebuffer. Macro MANDEL_DUAL_ENGINE_EN.
module mandel_pixel_scheduler
  import mandel_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                            clk,
  input  logic                            combined_rst_n,
  input  logic                            start,
  mandel_pixel_scheduler_if.master        bus,
  output logic                            busy,
  output logic                            frame_done
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
`ifdef MANDEL_DUAL_ENGINE_EN
  localparam logic DUAL = 1'b1;
`else
  localparam logic DUAL = 1'b0;
`endif

  sched_state_t         r_state, w_state_nxt;
  logic [XW-1:0]        r_x, r_eng_x;
  logic [YW-1:0]        r_y, r_eng_y;
  logic                 r_all_disp;
  logic [CW-1:0]        r_retired;
  logic                 r_disp_ptr, r_ret_ptr, r_outst;
  logic [1:0]           r_eng_run;
  logic                 r_fb_reset_ptr, r_fb_write, r_frame_done;
  logic [CTR_OUT_W-1:0] r_fb_data;
  logic                 w_go, w_disp, w_ret, w_ack, w_last;
  logic [1:0]           w_launch, w_take, w_inflight, w_valid;
  logic [CTR_OUT_W-1:0] w_val [2];

  mandel_result_slot u_slot0 (
    .clk, .combined_rst_n,
    .i_clr(w_go), .i_launch(w_launch[0]),
    .i_busy(bus.eng_busy[0]), .i_ctr(bus.eng_ctr0),
    .i_take(w_take[0]), .o_inflight(w_inflight[0]),
    .o_valid(w_valid[0]), .o_value(w_val[0])
  );

  mandel_result_slot u_slot1 (
    .clk, .combined_rst_n,
    .i_clr(w_go), .i_launch(w_launch[1]),
    .i_busy(bus.eng_busy[1]), .i_ctr(bus.eng_ctr1),
    .i_take(w_take[1]), .o_inflight(w_inflight[1]),
    .o_valid(w_valid[1]), .o_value(w_val[1])
  );

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) r_state <= IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go     = 1'b0;
    w_disp   = 1'b0;
    w_ret    = 1'b0;
    w_ack    = 1'b0;
    w_last   = 1'b0;
    w_launch = '0;
    w_take   = '0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_go        = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_disp = !r_all_disp && !w_inflight[r_disp_ptr]
                 && !w_valid[r_disp_ptr];
        w_ret  = w_valid[r_ret_ptr] && !r_outst;
        w_ack  = r_outst && bus.fb_wrote;
        w_last = w_ack && (r_retired == CW'(NPIX - 1));
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_launch[r_disp_ptr] = w_disp;
    w_take[r_ret_ptr]    = w_ack;
  end

  // pointers only toggle in dual mode, so both stay at engine 0 otherwise
  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      r_x            <= '0;
      r_y            <= '0;
      r_all_disp     <= 1'b0;
      r_retired      <= '0;
      r_disp_ptr     <= 1'b0;
      r_ret_ptr      <= 1'b0;
      r_outst        <= 1'b0;
      r_eng_run      <= '0;
      r_eng_x        <= '0;
      r_eng_y        <= '0;
      r_fb_reset_ptr <= 1'b0;
      r_fb_write     <= 1'b0;
      r_fb_data      <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_fb_reset_ptr <= w_go;
      r_eng_run      <= w_launch;
      r_fb_write     <= w_ret;
      r_frame_done   <= w_last;
      if (w_go) begin
        r_x        <= '0;
        r_y        <= '0;
        r_all_disp <= 1'b0;
        r_retired  <= '0;
        r_disp_ptr <= 1'b0;
        r_ret_ptr  <= 1'b0;
        r_outst    <= 1'b0;
      end else begin
        if (w_disp) begin
          r_eng_x    <= r_x;
          r_eng_y    <= r_y;
          r_disp_ptr <= DUAL & ~r_disp_ptr;
          if (r_x == XW'(WIDTH - 1)) begin
            r_x <= '0;
            if (r_y == YW'(HEIGHT - 1)) r_all_disp <= 1'b1;
            else                        r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        if (w_ret) begin
          r_fb_data <= w_val[r_ret_ptr];
          r_outst   <= 1'b1;
        end
        if (w_ack) begin
          r_outst   <= 1'b0;
          r_ret_ptr <= DUAL & ~r_ret_ptr;
          r_retired <= r_retired + 1'b1;
        end
      end
    end
  end

  assign bus.eng_run      = r_eng_run;
  assign bus.eng_x        = r_eng_x;
  assign bus.eng_y        = r_eng_y;
  assign bus.fb_reset_ptr = r_fb_reset_ptr;
  assign bus.fb_write     = r_fb_write;
  assign bus.fb_data      = r_fb_data;
  assign busy             = (r_state == RUN);
  assign frame_done       = r_frame_done;
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb_mandel_pixel_scheduler: 4x2 frame, modelled engines and
// framebuffer, launch/retire scoreboard.
module tb_mandel_pixel_scheduler;
  import mandel_sched_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
`ifdef MANDEL_DUAL_ENGINE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic combined_rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  mandel_pixel_scheduler_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  mandel_pixel_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk),
    .combined_rst_n(combined_rst_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int lat0 = 5, lat1 = 5, wdly = 2;
  bit rnd = 1'b0;
  int exp_q[$];
  int m_launch = 0, m_wrote = 0, m_fbw = 0;
  int m_done = 0, m_rptr = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  // engine and framebuffer models; a result is the value the engine returned
  initial begin : responder
    int cnt[2];
    int val[2];
    int wcnt;
    bit wpend;
    cnt = '{0, 0};
    val = '{0, 0};
    wcnt = 0;
    wpend = 1'b0;
    bus.eng_busy = '0;
    bus.eng_ctr0 = '0;
    bus.eng_ctr1 = '0;
    bus.fb_wrote = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.fb_wrote = 1'b0;
      if (!combined_rst_n) begin
        bus.eng_busy = '0;
        cnt = '{0, 0};
        wpend = 1'b0;
      end else begin
        for (int e = 0; e < 2; e++) begin
          if (cnt[e] > 0) begin
            cnt[e]--;
            if (cnt[e] == 0) begin
              bus.eng_busy[e] = 1'b0;
              if (e == 0) bus.eng_ctr0 = 4'(val[e]);
              else        bus.eng_ctr1 = 4'(val[e]);
            end
          end
          if (bus.eng_run[e]) begin
            val[e] = rnd ? int'($urandom_range(0, 15)) : (e == 0 ? 3 : 7);
            cnt[e] = rnd ? int'($urandom_range(1, 12)) : (e == 0 ? lat0 : lat1);
            bus.eng_busy[e] = 1'b1;
            if (e == 0) bus.eng_ctr0 = 4'($urandom);
            else        bus.eng_ctr1 = 4'($urandom);
            exp_q.push_back(val[e]);
          end
        end
        if (wpend) begin
          wcnt--;
          if (wcnt == 0) begin
            bus.fb_wrote = 1'b1;
            wpend = 1'b0;
          end
        end
        if (bus.fb_write) begin
          wpend = 1'b1;
          wcnt = rnd ? int'($urandom_range(1, 4)) : wdly;
        end
      end
    end
  end

  initial begin : monitor
    int e;
    int held;
    bit outst;
    bit prev_wrote;
    held = 0;
    outst = 1'b0;
    prev_wrote = 1'b0;
    forever begin
      @(negedge clk);
      if (!combined_rst_n) begin
        m_launch = 0;
        m_wrote = 0;
        m_fbw = 0;
        outst = 1'b0;
        prev_wrote = 1'b0;
        exp_q.delete();
      end else begin
        if (bus.fb_reset_ptr) begin
          chk("queue_empty_at_start", exp_q.size(), 0);
          m_rptr++;
          m_launch = 0;
          m_wrote = 0;
          m_fbw = 0;
        end
        if (frame_done) begin
          m_done++;
          chk("done_after_last_wrote", int'(prev_wrote), 1);
          chk("done_pixel_count", m_wrote, N);
          chk("busy_low_at_done", int'(busy), 0);
        end
        if (bus.eng_run != 2'b00) begin
          e = bus.eng_run[1] ? 1 : 0;
          chk("launch_onehot", $countones(bus.eng_run), 1);
          chk("launch_engine", e, DUAL ? m_launch % 2 : 0);
          chk("launch_x", int'(bus.eng_x), m_launch % W);
          chk("launch_y", int'(bus.eng_y), m_launch / W);
          chk("launch_slot_free",
              int'((m_launch - m_wrote) <= (DUAL ? 1 : 0)), 1);
          m_launch++;
        end
        if (bus.fb_write) begin
          chk("single_outstanding", int'(outst), 0);
          chk("fb_write_has_result", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("fb_data", int'(bus.fb_data), exp_q.pop_front());
          held = int'(bus.fb_data);
          outst = 1'b1;
          m_fbw++;
        end else if (outst) begin
          chk("fb_data_stable", int'(bus.fb_data), held);
        end
        if (bus.fb_wrote) begin
          outst = 1'b0;
          m_wrote++;
        end
        prev_wrote = bus.fb_wrote;
      end
    end
  end

  task automatic check_quiet(string tag);
    chk({tag, "_eng_run"}, int'(bus.eng_run), 0);
    chk({tag, "_eng_x"}, int'(bus.eng_x), 0);
    chk({tag, "_eng_y"}, int'(bus.eng_y), 0);
    chk({tag, "_fb_reset_ptr"}, int'(bus.fb_reset_ptr), 0);
    chk({tag, "_fb_write"}, int'(bus.fb_write), 0);
    chk({tag, "_fb_data"}, int'(bus.fb_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic run_frame(input int l0, input int l1, input int wd,
                           input bit r, input bit mid_start);
    int d0;
    int p0;
    int guard;
    lat0 = l0;
    lat1 = l1;
    wdly = wd;
    rnd = r;
    d0 = m_done;
    p0 = m_rptr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rptr_after_start", int'(bus.fb_reset_ptr), 1);
    chk("busy_after_start", int'(busy), 1);
    chk("no_run_with_rptr", int'(bus.eng_run), 0);
    @(negedge clk);
    chk("first_run", int'(bus.eng_run), 1);
    chk("first_xy", int'({bus.eng_x, bus.eng_y}), 0);
    if (mid_start) begin
      guard = 0;
      while (m_launch < 3 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_start_ignored", int'(bus.fb_reset_ptr), 0);
    end
    guard = 0;
    while (m_done == d0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_in_time", int'(guard < 5000), 1);
    repeat (5) @(negedge clk);
    chk("one_frame_done", m_done - d0, 1);
    chk("one_rptr", m_rptr - p0, 1);
    chk("launch_count", m_launch, N);
    chk("write_count", m_fbw, N);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int guard;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    combined_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("post_reset");

    run_frame(5, 5, 2, 1'b0, 1'b0);
    run_frame(20, 2, 2, 1'b0, 1'b0);
    run_frame(2, 2, 10, 1'b0, 1'b0);
    run_frame(0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_frame(0, 0, 0, 1'b1, 1'b0);

    lat0 = 4;
    lat1 = 4;
    wdly = 2;
    rnd = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (m_launch < 5 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_pixel5", int'(guard < 1000), 1);
    #2;
    combined_rst_n = 1'b0;
    #1;
    check_quiet("reset_mid");
    repeat (3) @(negedge clk);
    combined_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("after_abort");
    run_frame(5, 5, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
